// File: rtl/obi_boot_copy_pkg.sv
// Shared types and constants for the boot-image copy engine.
// The optional checksum is selected by the macro BOOT_COPY_CHECKSUM_EN.
package obi_boot_copy_pkg;

  localparam int unsigned AddrWidth = 32;
  localparam int unsigned DataWidth = 32;
  localparam int unsigned WordBytes = 4;
  localparam logic [3:0]  BeAll     = 4'hF;

  typedef enum logic [2:0] {
    IDLE,
    RD_REQ,
    RD_RSP,
    WR_REQ,
    WR_RSP,
    DONE,
    ERROR
  } boot_copy_state_e;

  // Byte address of word idx relative to base; wraps silently at 2^AddrWidth.
  function automatic logic [AddrWidth-1:0] word_addr(input logic [AddrWidth-1:0] base,
                                                     input logic [AddrWidth-1:0] idx);
    return base + idx * WordBytes;
  endfunction

endpackage

// File: rtl/obi_boot_copy_if.sv
// OBI manager-side bundle: request channel (req/we/be/addr/wdata/aid),
// grant and response channel (gnt/rvalid/rdata/err).
interface obi_boot_copy_if #(
  parameter int unsigned IdWidth = 1
) ();
  import obi_boot_copy_pkg::*;

  logic                 req;
  logic                 gnt;
  logic                 we;
  logic [3:0]           be;
  logic [AddrWidth-1:0] addr;
  logic [DataWidth-1:0] wdata;
  logic [IdWidth-1:0]   aid;
  logic                 rvalid;
  logic [DataWidth-1:0] rdata;
  logic                 err;

  modport master (
    output req, we, be, addr, wdata, aid,
    input  gnt, rvalid, rdata, err
  );

  modport slave (
    input  req, we, be, addr, wdata, aid,
    output gnt, rvalid, rdata, err
  );

endinterface

// File: rtl/obi_boot_copy_csum.sv
// Mod-2^32 accumulator for the copied words. Only compiled when
// BOOT_COPY_CHECKSUM_EN is defined; otherwise the checksum logic is absent.
`ifdef BOOT_COPY_CHECKSUM_EN
module obi_boot_copy_csum
  import obi_boot_copy_pkg::*;
(
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 clr_i,
  input  logic                 en_i,
  input  logic [DataWidth-1:0] data_i,
  output logic [31:0]          sum_o
);

  logic [31:0] sum_q, sum_d;

  // Clear wins over accumulate so a restart never folds in a stale word.
  always_comb begin
    sum_d = sum_q;
    if (clr_i) begin
      sum_d = '0;
    end else if (en_i) begin
      sum_d = sum_q + data_i;
    end
  end

  // Accumulator register.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sum_q <= '0;
    end else begin
      sum_q <= sum_d;
    end
  end

  assign sum_o = sum_q;

endmodule
`endif

// File: rtl/obi_boot_copy.sv
// Boot-image copy engine: reads LenBytes from SrcAddr over OBI and writes them
// to DstAddr, one outstanding transaction at a time.
// Optional running checksum enabled by macro BOOT_COPY_CHECKSUM_EN.
//
// state  | meaning
// IDLE   | waiting for start_i after reset
// RD_REQ | read request on the bus, waiting for gnt
// RD_RSP | waiting for read rvalid, word lands in the buffer
// WR_REQ | write request of the buffered word, waiting for gnt
// WR_RSP | waiting for write rvalid, then next word or DONE
// DONE   | copy finished cleanly, start_i restarts
// ERROR  | copy aborted on r.err, start_i restarts
module obi_boot_copy
  import obi_boot_copy_pkg::*;
#(
  parameter logic [AddrWidth-1:0] SrcAddr  = 32'h0300_D000,
  parameter logic [AddrWidth-1:0] DstAddr  = 32'h1000_0000,
  parameter int unsigned          LenBytes = 'h1000,
  localparam int unsigned         NumWords = LenBytes / WordBytes,
  localparam int unsigned         WordsW   = (NumWords == 0) ? 1 : $clog2(NumWords + 1)
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  start_i,
  output logic                  busy_o,
  output logic                  done_o,
  output logic                  err_o,
  output logic [WordsW-1:0]     words_o,
  output logic [31:0]           checksum_o,
  obi_boot_copy_if.master       obi
);

  localparam logic [WordsW-1:0] LastIdx = WordsW'((NumWords == 0) ? 0 : NumWords - 1);

  boot_copy_state_e     state_q;
  logic                 req_q, we_q, busy_q, done_q, err_q;
  logic [3:0]           be_q;
  logic [AddrWidth-1:0] addr_q;
  logic [DataWidth-1:0] wdata_q;
  logic [WordsW-1:0]    words_q;

  // Copy sequencer; every bus field and status output is a register.
  // The word counter doubles as the copy index.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= IDLE;
      req_q   <= 1'b0;
      we_q    <= 1'b0;
      be_q    <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      words_q <= '0;
    end else begin
      unique case (state_q)
        IDLE, DONE, ERROR: begin
          if (start_i) begin
            done_q  <= 1'b0;
            err_q   <= 1'b0;
            words_q <= '0;
            if (NumWords == 0) begin
              state_q <= DONE;
              done_q  <= 1'b1;
            end else begin
              state_q <= RD_REQ;
              busy_q  <= 1'b1;
              req_q   <= 1'b1;
              we_q    <= 1'b0;
              be_q    <= BeAll;
              addr_q  <= SrcAddr;
            end
          end
        end
        RD_REQ: begin
          if (obi.gnt) begin
            state_q <= RD_RSP;
            req_q   <= 1'b0;
          end
        end
        RD_RSP: begin
          if (obi.rvalid) begin
            wdata_q <= obi.rdata;
            if (obi.err) begin
              state_q <= ERROR;
              busy_q  <= 1'b0;
              err_q   <= 1'b1;
            end else begin
              state_q <= WR_REQ;
              req_q   <= 1'b1;
              we_q    <= 1'b1;
              addr_q  <= word_addr(DstAddr, 32'(words_q));
            end
          end
        end
        WR_REQ: begin
          if (obi.gnt) begin
            state_q <= WR_RSP;
            req_q   <= 1'b0;
          end
        end
        WR_RSP: begin
          if (obi.rvalid) begin
            we_q <= 1'b0;
            if (obi.err) begin
              state_q <= ERROR;
              busy_q  <= 1'b0;
              err_q   <= 1'b1;
            end else begin
              words_q <= words_q + 1'b1;
              if (words_q == LastIdx) begin
                state_q <= DONE;
                busy_q  <= 1'b0;
                done_q  <= 1'b1;
              end else begin
                state_q <= RD_REQ;
                req_q   <= 1'b1;
                addr_q  <= word_addr(SrcAddr, 32'(words_q) + 32'd1);
              end
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

`ifdef BOOT_COPY_CHECKSUM_EN
  logic csum_clr, csum_en;

  assign csum_clr = start_i && (state_q inside {IDLE, DONE, ERROR});
  assign csum_en  = (state_q == RD_RSP) && obi.rvalid && !obi.err;

  obi_boot_copy_csum u_csum (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .clr_i  (csum_clr),
    .en_i   (csum_en),
    .data_i (obi.rdata),
    .sum_o  (checksum_o)
  );
`else
  assign checksum_o = 32'h0;
`endif

  assign obi.req   = req_q;
  assign obi.we    = we_q;
  assign obi.be    = be_q;
  assign obi.addr  = addr_q;
  assign obi.wdata = wdata_q;
  assign obi.aid   = '0;

  assign busy_o  = busy_q;
  assign done_o  = done_q;
  assign err_o   = err_q;
  assign words_o = words_q;

endmodule
